// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_ctrl_pkg
// Description : Shared types and default widths for the RAM access controller.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_ctrl_pkg;

    localparam int MEM_DATA_WIDTH = 32;
    localparam int MEM_ADDR_WIDTH = 9;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        DONE   = 2'd3
    } state_t;

    typedef enum logic [0:0] {
        OP_CPU  = 1'b0,
        OP_LOAD = 1'b1
    } op_t;

endpackage
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_ctrl
// Description : Sequences CPU and boot-preload accesses onto the strobed RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = MEM_DATA_WIDTH,
    parameter int ADDR_WIDTH = MEM_ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_read,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  done,
    output logic                  err,
    output logic [DATA_WIDTH-1:0] rdata,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [DATA_WIDTH-1:0] ld_data,
    output logic [ADDR_WIDTH:0]   ld_count,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  mem_enable,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    input  logic [DATA_WIDTH-1:0] mem_data_out,
    output logic                  mem_override,
    output logic [ADDR_WIDTH-1:0] mem_override_address,
    output logic [DATA_WIDTH-1:0] mem_override_data_in
);

    localparam logic [ADDR_WIDTH:0] c_ld_max = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_t                r_state, w_state_next;
    op_t                   r_op, w_op_next;

    logic                  r_done, w_done;
    logic                  r_err, w_err;
    logic [DATA_WIDTH-1:0] r_rdata, w_rdata;
    logic [ADDR_WIDTH:0]   r_ld_count, w_ld_count;
    logic                  r_mem_read, w_mem_read;
    logic                  r_mem_write, w_mem_write;
    logic                  r_mem_enable, w_mem_enable;
    logic [ADDR_WIDTH-1:0] r_mem_address, w_mem_address;
    logic [DATA_WIDTH-1:0] r_mem_data_in, w_mem_data_in;
    logic                  r_mem_override, w_mem_override;
    logic [ADDR_WIDTH-1:0] r_ov_address, w_ov_address;
    logic [DATA_WIDTH-1:0] r_ov_data, w_ov_data;

    logic                  w_req_legal;

    assign w_req_legal = req_read ^ req_write;

    // State and every registered output share one register process.
    always_ff @(posedge clock) begin
        if (clear) begin
            r_state        <= IDLE;
            r_op           <= OP_CPU;
            r_done         <= 1'b0;
            r_err          <= 1'b0;
            r_rdata        <= '0;
            r_ld_count     <= '0;
            r_mem_read     <= 1'b0;
            r_mem_write    <= 1'b0;
            r_mem_enable   <= 1'b0;
            r_mem_address  <= '0;
            r_mem_data_in  <= '0;
            r_mem_override <= 1'b0;
            r_ov_address   <= '0;
            r_ov_data      <= '0;
        end else begin
            r_state        <= w_state_next;
            r_op           <= w_op_next;
            r_done         <= w_done;
            r_err          <= w_err;
            r_rdata        <= w_rdata;
            r_ld_count     <= w_ld_count;
            r_mem_read     <= w_mem_read;
            r_mem_write    <= w_mem_write;
            r_mem_enable   <= w_mem_enable;
            r_mem_address  <= w_mem_address;
            r_mem_data_in  <= w_mem_data_in;
            r_mem_override <= w_mem_override;
            r_ov_address   <= w_ov_address;
            r_ov_data      <= w_ov_data;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_op_next    = r_op;
        case (r_state)
            IDLE: begin
                if (ld_valid) begin
                    w_state_next = SETUP;
                    w_op_next    = OP_LOAD;
                end else if (req_valid) begin
                    w_op_next    = OP_CPU;
                    // Malformed requests complete immediately without a strobe.
                    w_state_next = w_req_legal ? SETUP : DONE;
                end
            end
            SETUP:   w_state_next = STROBE;
            STROBE:  w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_done         = r_done;
        w_err          = r_err;
        w_rdata        = r_rdata;
        w_ld_count     = r_ld_count;
        w_mem_read     = r_mem_read;
        w_mem_write    = r_mem_write;
        w_mem_enable   = r_mem_enable;
        w_mem_address  = r_mem_address;
        w_mem_data_in  = r_mem_data_in;
        w_mem_override = r_mem_override;
        w_ov_address   = r_ov_address;
        w_ov_data      = r_ov_data;
        case (r_state)
            IDLE: begin
                if (ld_valid) begin
                    w_mem_read     = 1'b0;
                    w_mem_write    = 1'b0;
                    w_mem_override = 1'b1;
                    w_ov_address   = ld_addr;
                    w_ov_data      = ld_data;
                end else if (req_valid) begin
                    if (w_req_legal) begin
                        w_mem_read     = req_read;
                        w_mem_write    = req_write;
                        w_mem_address  = req_addr;
                        w_mem_data_in  = req_read ? '0 : req_wdata;
                        w_mem_override = 1'b0;
                    end else begin
                        w_done = 1'b1;
                        w_err  = 1'b1;
                    end
                end
            end
            SETUP: w_mem_enable = 1'b1;
            STROBE: begin
                w_mem_enable = 1'b0;
                if (r_op == OP_CPU) begin
                    w_done = 1'b1;
                    if (r_mem_read) begin
                        w_rdata = mem_data_out;
                    end
                end else if (r_ld_count != c_ld_max) begin
                    w_ld_count = r_ld_count + (ADDR_WIDTH+1)'(1);
                end
            end
            DONE: begin
                w_done         = 1'b0;
                w_err          = 1'b0;
                w_mem_read     = 1'b0;
                w_mem_write    = 1'b0;
                w_mem_override = 1'b0;
            end
            default: ;
        endcase
    end

    assign req_ready            = (r_state == IDLE);
    assign ld_ready             = (r_state == IDLE);
    assign done                 = r_done;
    assign err                  = r_err;
    assign rdata                = r_rdata;
    assign ld_count             = r_ld_count;
    assign mem_read             = r_mem_read;
    assign mem_write            = r_mem_write;
    assign mem_enable           = r_mem_enable;
    assign mem_address          = r_mem_address;
    assign mem_data_in          = r_mem_data_in;
    assign mem_override         = r_mem_override;
    assign mem_override_address = r_ov_address;
    assign mem_override_data_in = r_ov_data;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_ctrl
// Description : Directed self-checking bench with a behavioural strobed RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_ctrl;

    logic        clock;
    logic        clear;
    logic        req_valid, req_ready, req_read, req_write;
    logic [8:0]  req_addr;
    logic [31:0] req_wdata;
    logic        done, err;
    logic [31:0] rdata;
    logic        ld_valid, ld_ready;
    logic [8:0]  ld_addr;
    logic [31:0] ld_data;
    logic [9:0]  ld_count;
    logic        mem_read, mem_write, mem_enable, mem_override;
    logic [8:0]  mem_address, mem_override_address;
    logic [31:0] mem_data_in, mem_data_out, mem_override_data_in;

    int n_cmp  = 0;
    int n_fail = 0;

    mem_access_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(9)) dut (
        .clock(clock), .clear(clear),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_read(req_read), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .done(done), .err(err), .rdata(rdata),
        .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_addr(ld_addr), .ld_data(ld_data), .ld_count(ld_count),
        .mem_read(mem_read), .mem_write(mem_write), .mem_enable(mem_enable),
        .mem_address(mem_address), .mem_data_in(mem_data_in),
        .mem_data_out(mem_data_out), .mem_override(mem_override),
        .mem_override_address(mem_override_address),
        .mem_override_data_in(mem_override_data_in)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural RAM: acts only on the enable rising edge.
    logic [31:0] ram [512];
    initial begin
        for (int i = 0; i < 512; i++) ram[i] = 32'h0;
        mem_data_out = 32'h0;
    end
    always @(posedge mem_enable) begin
        if (mem_override)   ram[mem_override_address] <= mem_override_data_in;
        else if (mem_write) ram[mem_address] <= mem_data_in;
        else if (mem_read)  mem_data_out <= ram[mem_address];
    end

    // Counts enable rises and flags any RAM input that moved in the cycle before one.
    int          en_edges = 0;
    int          unstable = 0;
    logic        p_en, p_rd, p_wr, p_ov;
    logic [8:0]  p_addr, p_ovaddr;
    logic [31:0] p_din, p_ovdata;
    always @(negedge clock) begin
        if (mem_enable === 1'b1 && p_en === 1'b0) begin
            en_edges <= en_edges + 1;
            if (mem_address !== p_addr || mem_data_in !== p_din || mem_read !== p_rd ||
                mem_write !== p_wr || mem_override !== p_ov ||
                mem_override_address !== p_ovaddr || mem_override_data_in !== p_ovdata)
                unstable <= unstable + 1;
        end
        p_en     <= mem_enable;
        p_rd     <= mem_read;
        p_wr     <= mem_write;
        p_ov     <= mem_override;
        p_addr   <= mem_address;
        p_din    <= mem_data_in;
        p_ovaddr <= mem_override_address;
        p_ovdata <= mem_override_data_in;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic preload(input logic [8:0] a, input logic [31:0] d);
        ld_valid = 1'b1;
        ld_addr  = a;
        ld_data  = d;
        tick();
        ld_valid = 1'b0;
        tick();
        tick();
        tick();
    endtask

    // Full CPU access; request inputs are scrambled after accept to prove they are not re-sampled.
    task automatic cpu_access(input logic rd, input logic wr, input logic [8:0] a,
                              input logic [31:0] wd, input logic [31:0] exp_rdata,
                              input string tag);
        req_valid = 1'b1;
        req_read  = rd;
        req_write = wr;
        req_addr  = a;
        req_wdata = wd;
        tick();
        req_valid = 1'b0;
        req_addr  = ~a;
        req_wdata = ~wd;
        check({tag, "_addr"}, 32'(mem_address), 32'(a));
        check({tag, "_done_e0"}, 32'(done), 32'd0);
        tick();
        check({tag, "_en_e1"}, 32'(mem_enable), 32'd1);
        tick();
        check({tag, "_done_e2"}, 32'(done), 32'd1);
        check({tag, "_err_e2"}, 32'(err), 32'd0);
        check({tag, "_rdata"}, rdata, exp_rdata);
        tick();
        check({tag, "_done_e3"}, 32'(done), 32'd0);
    endtask

    function automatic logic [31:0] pattern(input int i);
        return 32'hC0DE_0000 ^ 32'(i);
    endfunction

    initial begin
        int e0;
        clear = 1'b1; req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0;
        req_addr = '0; req_wdata = '0; ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
        tick();
        tick();
        clear = 1'b0;
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_ldcount", 32'(ld_count), 32'd0);
        check("rst_enable", 32'(mem_enable), 32'd0);
        check("rst_override", 32'(mem_override), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd1);

        // Preload then read back through the CPU path.
        ld_valid = 1'b1; ld_addr = 9'd5; ld_data = 32'hDEADBEEF;
        tick();
        ld_valid = 1'b0;
        check("pl_setup_ov", 32'(mem_override), 32'd1);
        check("pl_setup_en", 32'(mem_enable), 32'd0);
        check("pl_ldready", 32'(ld_ready), 32'd0);
        tick();
        check("pl_strobe_en", 32'(mem_enable), 32'd1);
        check("pl_strobe_ov", 32'(mem_override), 32'd1);
        check("pl_ov_addr", 32'(mem_override_address), 32'd5);
        tick();
        check("pl_ldcount", 32'(ld_count), 32'd1);
        check("pl_no_done", 32'(done), 32'd0);
        tick();
        check("pl_ov_off", 32'(mem_override), 32'd0);
        check("pl_ready", 32'(req_ready), 32'd1);
        cpu_access(1'b1, 1'b0, 9'd5, 32'h0, 32'hDEADBEEF, "rd5");

        // Write/read at the top address; rdata must survive the write.
        e0 = en_edges;
        cpu_access(1'b0, 1'b1, 9'h1FF, 32'h12345678, 32'hDEADBEEF, "wr1ff");
        check("ram_1ff", ram[9'h1FF], 32'h12345678);
        cpu_access(1'b1, 1'b0, 9'h1FF, 32'h0, 32'h12345678, "rd1ff");
        check("en_edges_2", 32'(en_edges - e0), 32'd2);

        // Malformed requests: both and neither of read/write.
        e0 = en_edges;
        req_valid = 1'b1; req_read = 1'b1; req_write = 1'b1; req_addr = 9'd5; req_wdata = 32'h0;
        tick();
        req_valid = 1'b0;
        check("bad_done", 32'(done), 32'd1);
        check("bad_err", 32'(err), 32'd1);
        check("bad_en", 32'(mem_enable), 32'd0);
        tick();
        check("bad_done_off", 32'(done), 32'd0);
        check("bad_err_off", 32'(err), 32'd0);
        check("bad_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_read = 1'b0; req_write = 1'b0;
        tick();
        req_valid = 1'b0;
        check("none_err", 32'(err), 32'd1);
        tick();
        tick();
        check("bad_no_strobe", 32'(en_edges - e0), 32'd0);
        check("bad_ram5", ram[5], 32'hDEADBEEF);
        check("bad_rdata", rdata, 32'h12345678);

        // Preload and CPU request in the same cycle.
        ld_valid = 1'b1; ld_addr = 9'd10; ld_data = 32'hA5A5A5A5;
        req_valid = 1'b1; req_read = 1'b1; req_write = 1'b0; req_addr = 9'd10;
        tick();
        ld_valid = 1'b0;
        check("sim_ov", 32'(mem_override), 32'd1);
        check("sim_rd", 32'(mem_read), 32'd0);
        check("sim_ready_e0", 32'(req_ready), 32'd0);
        tick();
        check("sim_ready_e1", 32'(req_ready), 32'd0);
        tick();
        check("sim_ldcount", 32'(ld_count), 32'd2);
        check("sim_no_done", 32'(done), 32'd0);
        check("sim_ready_e2", 32'(req_ready), 32'd0);
        tick();
        check("sim_ready_e3", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        check("sim_cpu_rd", 32'(mem_read), 32'd1);
        check("sim_cpu_addr", 32'(mem_address), 32'd10);
        tick();
        tick();
        check("sim_done", 32'(done), 32'd1);
        check("sim_rdata", rdata, 32'hA5A5A5A5);
        tick();

        // Clear while the read strobe is high.
        req_valid = 1'b1; req_read = 1'b1; req_write = 1'b0; req_addr = 9'h1FF;
        tick();
        req_valid = 1'b0;
        tick();
        check("clr_en_before", 32'(mem_enable), 32'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_en", 32'(mem_enable), 32'd0);
        check("clr_done", 32'(done), 32'd0);
        check("clr_rdata", rdata, 32'd0);
        check("clr_ldcount", 32'(ld_count), 32'd0);
        check("clr_rd", 32'(mem_read), 32'd0);
        check("clr_ready", 32'(req_ready), 32'd1);
        tick();
        tick();
        check("clr_no_done", 32'(done), 32'd0);

        // Fill the whole RAM, then one extra preload to hit saturation.
        for (int i = 0; i < 512; i++) preload(9'(i), pattern(i));
        check("sat_512", 32'(ld_count), 32'd512);
        preload(9'd0, pattern(0));
        check("sat_513", 32'(ld_count), 32'd512);
        cpu_access(1'b1, 1'b0, 9'd0, 32'h0, pattern(0), "rd0");
        cpu_access(1'b1, 1'b0, 9'd255, 32'h0, pattern(255), "rd255");
        cpu_access(1'b1, 1'b0, 9'd511, 32'h0, pattern(511), "rd511");

        check("stable_setup", 32'(unstable), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
